mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the core's instruction-fetch channel and data-access channel onto one shared memory port, sitting between the pipeline and the cache/memory interface. Grants one transaction at a time and holds the grant until the memory responds with data_ok. Data requests win by default. A starvation counter guarantees that fetch is eventually served. Fetch responses are narrowed to the addressed 32-bit word.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants made while fetch is pending before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  in  1  fetch request.
- ireq_addr  in  64  fetch address (4-byte aligned).
- iresp_data_ok  out  1  fetch completion, asserted for one cycle.
- iresp_data  out  32  fetched instruction.
- dreq_valid  in  1  data request.
- dreq_addr  in  64  data address.
- dreq_size  in  3  0=1B, 1=2B, 2=4B, 3=8B.
- dreq_strobe  in  8  byte enables; nonzero means write.
- dreq_data  in  64  write data.
- dresp_data_ok  out  1  data completion, asserted for one cycle.
- dresp_data  out  64  read data (raw 64-bit beat).
- mreq_valid  out  1  shared-port request.
- mreq_addr  out  64  shared-port address.
- mreq_size  out  3  shared-port size.
- mreq_strobe  out  8  shared-port byte enables (0 = read).
- mreq_data  out  64  shared-port write data.
- mresp_data_ok  in  1  memory completion.
- mresp_data  in  64  memory read data.
- owner  out  1  current grant holder: 0 = fetch, 1 = data; valid while BUSY.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: a request is latched and driven onto the shared port.
- Arbitration (IDLE only):
  - Only one valid: grant it.
  - Both valid: grant data unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
  - Neither valid: stay IDLE.
- On grant:
  - Latch addr, size, strobe and data into request registers.
  - Fetch grants latch size 2 and strobe 0.
  - Set owner; go to BUSY.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while ireq_valid = 1.
  - Clears on any fetch grant, and on any IDLE cycle with ireq_valid = 0.
- BUSY:
  - mreq_* is driven from the latched registers and held stable until mresp_data_ok.
  - Requester inputs are ignored while BUSY.
- Completion (BUSY and mresp_data_ok):
  - Route the response to the owner: iresp_data_ok = 1 or dresp_data_ok = 1.
  - Go to IDLE.
- Response data:
  - iresp_data = latched_addr[2] ? mresp_data[63:32] : mresp_data[31:0].
  - dresp_data = mresp_data unmodified; byte alignment belongs downstream.
- Abandoned request:
  - If the owner drops its valid while BUSY, the shared transaction still runs to mresp_data_ok, because memory cannot abort.
  - The completion pulse to that requester is suppressed.
  - "Dropped" is recorded in a flag register, set on any BUSY cycle where the owner's valid = 0.
- Unowned side:
  - The non-owner *_data_ok stays 0 at all times.
  - mresp_data_ok while IDLE is ignored.

## Timing
- Reset (asynchronous, any state, including mid-transaction): state = IDLE, owner = 0, starve_cnt = 0, dropped = 0, and all request registers = 0. This gives mreq_valid = 0, iresp_data_ok = 0 and dresp_data_ok = 0. An in-flight memory response after reset is ignored.
- Grant latency:
  - Request valid in IDLE cycle N: grant registered at the edge ending N; mreq_valid = 1 in cycle N+1.
  - mreq_valid is registered and never combinational from the requester inputs.
- Completion path:
  - mresp_data_ok in cycle M: the owner's data_ok and data are combinational in cycle M.
  - FSM is IDLE in M+1; earliest next mreq_valid is M+2.
- Requesters keep valid and payload stable until their data_ok (codebase rule). A requester still asserting valid in M+1 is treated as a new request.
- Minimum transaction occupancy: 2 cycles per access (1 IDLE arbitration cycle + ≥1 BUSY cycle).

## Test plan
- Lone fetch:
  - Stimulus: ireq_valid=1, addr=0x8000_0004; memory returns 0x1111_2222_3333_4444 two cycles later.
  - Required: mreq_valid rises 1 cycle after request with strobe=0 and size=2; iresp_data=0x1111_2222 with a one-cycle iresp_data_ok; dresp_data_ok stays 0.
- Simultaneous requests:
  - Stimulus: fetch and data (write, strobe=0xFF, data=0xDEAD_BEEF) both valid in the same cycle.
  - Required: data granted first (owner=1, mreq_strobe=0xFF); after its completion, fetch is granted next.
- Starvation:
  - Stimulus: STARVE_LIMIT=4; fetch held valid; data re-requests every cycle.
  - Required: exactly 4 data grants, then a fetch grant, with starve_cnt returning to 0.
- Abandoned request:
  - Stimulus: grant to fetch, then ireq_valid drops during BUSY; memory completes 3 cycles later.
  - Required: mreq stays stable until mresp_data_ok; iresp_data_ok never pulses; FSM returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while BUSY with a data write.
  - Required: mreq_valid drops to 0 without waiting for a clock edge; a later mresp_data_ok produces no dresp_data_ok; the next request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data-access channels.
// One transaction at a time, data preferred, with a starvation counter that guarantees fetch progress.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        mreq_valid,
    output logic [63:0] mreq_addr,
    output logic [2:0]  mreq_size,
    output logic [7:0]  mreq_strobe,
    output logic [63:0] mreq_data,
    input  logic        mresp_data_ok,
    input  logic [63:0] mresp_data,
    output logic        owner
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_t      r_state;
    logic        r_owner;
    logic        r_dropped;
    logic [3:0]  r_starve_cnt;
    logic [63:0] r_addr;
    logic [2:0]  r_size;
    logic [7:0]  r_strobe;
    logic [63:0] r_data;

    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_owner_valid;
    logic        w_done;

    // Arbitration decode: data wins unless fetch has been passed over STARVE_LIMIT times.
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (dreq_valid && (!ireq_valid || (r_starve_cnt != LIMIT_C))) begin
            w_grant_d = 1'b1;
        end else if (ireq_valid) begin
            w_grant_i = 1'b1;
        end else begin
            w_grant_d = 1'b0;
            w_grant_i = 1'b0;
        end
    end

    // Grant FSM, request latches, starvation counter and abandoned-request flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_dropped    <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_addr       <= 64'd0;
            r_size       <= 3'd0;
            r_strobe     <= 8'd0;
            r_data       <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= ST_BUSY;
                        r_owner   <= 1'b1;
                        r_dropped <= 1'b0;
                        r_addr    <= dreq_addr;
                        r_size    <= dreq_size;
                        r_strobe  <= dreq_strobe;
                        r_data    <= dreq_data;
                        if (!ireq_valid) begin
                            r_starve_cnt <= 4'd0;
                        end else if (r_starve_cnt != LIMIT_C) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end else if (w_grant_i) begin
                        r_state      <= ST_BUSY;
                        r_owner      <= 1'b0;
                        r_dropped    <= 1'b0;
                        r_addr       <= ireq_addr;
                        r_size       <= 3'd2;
                        r_strobe     <= 8'd0;
                        r_data       <= 64'd0;
                        r_starve_cnt <= 4'd0;
                    end else begin
                        r_starve_cnt <= 4'd0;
                    end
                end
                ST_BUSY: begin
                    // Memory cannot abort, so a withdrawn request still runs to completion.
                    if (!w_owner_valid) begin
                        r_dropped <= 1'b1;
                    end
                    if (mresp_data_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response routing and shared-port drive from the latched request.
    always_comb begin
        w_owner_valid = r_owner ? dreq_valid : ireq_valid;
        w_done        = (r_state == ST_BUSY) && mresp_data_ok && w_owner_valid && !r_dropped;
        iresp_data_ok = w_done && !r_owner;
        dresp_data_ok = w_done && r_owner;
        if (r_addr[2]) begin
            iresp_data = mresp_data[63:32];
        end else begin
            iresp_data = mresp_data[31:0];
        end
        dresp_data  = mresp_data;
        mreq_valid  = (r_state == ST_BUSY);
        mreq_addr   = r_addr;
        mreq_size   = r_size;
        mreq_strobe = r_strobe;
        mreq_data   = r_data;
        owner       = r_owner;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the scenarios of the test plan.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid = 1'b0;
    logic [63:0] ireq_addr = 64'd0;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid = 1'b0;
    logic [63:0] dreq_addr = 64'd0;
    logic [2:0]  dreq_size = 3'd0;
    logic [7:0]  dreq_strobe = 8'd0;
    logic [63:0] dreq_data = 64'd0;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        mreq_valid;
    logic [63:0] mreq_addr;
    logic [2:0]  mreq_size;
    logic [7:0]  mreq_strobe;
    logic [63:0] mreq_data;
    logic        mresp_data_ok = 1'b0;
    logic [63:0] mresp_data = 64'd0;
    logic        owner;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
        .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
        .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one outstanding transaction, winner chosen by a fairness rule.
    bit          m_busy = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_abandoned = 1'b0;
    int          m_passed_over = 0;
    logic [63:0] m_addr = 64'd0;
    logic [2:0]  m_size = 3'd0;
    logic [7:0]  m_strobe = 8'd0;
    logic [63:0] m_data = 64'd0;

    // Returns 1 = data, 0 = fetch, -1 = nobody.
    function automatic int pick_winner(input bit want_i, input bit want_d, input int passed_over);
        if (want_d && want_i) return (passed_over >= LIMIT) ? 0 : 1;
        if (want_d) return 1;
        if (want_i) return 0;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_owner <= 1'b0; m_abandoned <= 1'b0; m_passed_over <= 0;
            m_addr <= 64'd0; m_size <= 3'd0; m_strobe <= 8'd0; m_data <= 64'd0;
        end else if (!m_busy) begin
            case (pick_winner(ireq_valid, dreq_valid, m_passed_over))
                1: begin
                    m_busy <= 1'b1; m_owner <= 1'b1; m_abandoned <= 1'b0;
                    m_addr <= dreq_addr; m_size <= dreq_size;
                    m_strobe <= dreq_strobe; m_data <= dreq_data;
                    m_passed_over <= ireq_valid ? ((m_passed_over + 1 > LIMIT) ? LIMIT : m_passed_over + 1) : 0;
                end
                0: begin
                    m_busy <= 1'b1; m_owner <= 1'b0; m_abandoned <= 1'b0;
                    m_addr <= ireq_addr; m_size <= 3'd2; m_strobe <= 8'd0; m_data <= 64'd0;
                    m_passed_over <= 0;
                end
                default: m_passed_over <= 0;
            endcase
        end else begin
            if (!(m_owner ? dreq_valid : ireq_valid)) m_abandoned <= 1'b1;
            if (mresp_data_ok) m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_done;
        exp_done = m_busy && mresp_data_ok && !m_abandoned && (m_owner ? dreq_valid : ireq_valid);
        check("mreq_valid", {63'd0, mreq_valid}, {63'd0, m_busy});
        if (m_busy) begin
            check("owner", {63'd0, owner}, {63'd0, m_owner});
            check("mreq_addr", mreq_addr, m_addr);
            check("mreq_size", {61'd0, mreq_size}, {61'd0, m_size});
            check("mreq_strobe", {56'd0, mreq_strobe}, {56'd0, m_strobe});
            check("mreq_data", mreq_data, m_data);
        end
        check("iresp_data_ok", {63'd0, iresp_data_ok}, {63'd0, exp_done && !m_owner});
        check("dresp_data_ok", {63'd0, dresp_data_ok}, {63'd0, exp_done && m_owner});
        if (exp_done && !m_owner)
            check("iresp_data", {32'd0, iresp_data},
                  {32'd0, (m_addr[2] ? mresp_data[63:32] : mresp_data[31:0])});
        if (exp_done && m_owner)
            check("dresp_data", dresp_data, mresp_data);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit owners[$];
        bit fetch_seen;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mreq_valid", {63'd0, mreq_valid}, 64'd0);
        check("rst_owner", {63'd0, owner}, 64'd0);
        check("rst_iresp_ok", {63'd0, iresp_data_ok}, 64'd0);
        check("rst_dresp_ok", {63'd0, dresp_data_ok}, 64'd0);

        // Lone fetch of the upper word.
        ireq_valid = 1'b1; ireq_addr = 64'h0000_0000_8000_0004;
        tick();
        check("t1_mreq_valid", {63'd0, mreq_valid}, 64'd1);
        check("t1_strobe", {56'd0, mreq_strobe}, 64'd0);
        check("t1_size", {61'd0, mreq_size}, 64'd2);
        check("t1_addr", mreq_addr, 64'h0000_0000_8000_0004);
        tick();
        mresp_data_ok = 1'b1; mresp_data = 64'h1111_2222_3333_4444;
        #1;
        check("t1_iresp_ok", {63'd0, iresp_data_ok}, 64'd1);
        check("t1_iresp_data", {32'd0, iresp_data}, 64'h0000_0000_1111_2222);
        check("t1_dresp_ok", {63'd0, dresp_data_ok}, 64'd0);
        tick();
        mresp_data_ok = 1'b0; ireq_valid = 1'b0;
        #1;
        check("t1_idle", {63'd0, mreq_valid}, 64'd0);
        check("t1_iresp_pulse", {63'd0, iresp_data_ok}, 64'd0);

        // Simultaneous requests: data first, then fetch.
        tick();
        ireq_valid = 1'b1; ireq_addr = 64'h1000;
        dreq_valid = 1'b1; dreq_addr = 64'h2000; dreq_size = 3'd3;
        dreq_strobe = 8'hFF; dreq_data = 64'h0000_0000_DEAD_BEEF;
        tick();
        check("t2_owner", {63'd0, owner}, 64'd1);
        check("t2_strobe", {56'd0, mreq_strobe}, 64'h00FF);
        check("t2_data", mreq_data, 64'h0000_0000_DEAD_BEEF);
        mresp_data_ok = 1'b1; mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        check("t2_dresp_ok", {63'd0, dresp_data_ok}, 64'd1);
        check("t2_dresp_data", dresp_data, 64'hAAAA_BBBB_CCCC_DDDD);
        check("t2_iresp_ok", {63'd0, iresp_data_ok}, 64'd0);
        tick();
        mresp_data_ok = 1'b0; dreq_valid = 1'b0; dreq_strobe = 8'h00;
        tick();
        check("t2_fetch_owner", {63'd0, owner}, 64'd0);
        check("t2_fetch_valid", {63'd0, mreq_valid}, 64'd1);
        check("t2_fetch_addr", mreq_addr, 64'h1000);
        mresp_data_ok = 1'b1; mresp_data = 64'h0123_4567_89AB_CDEF;
        #1;
        check("t2_iresp_data", {32'd0, iresp_data}, 64'h0000_0000_89AB_CDEF);
        tick();
        mresp_data_ok = 1'b0; ireq_valid = 1'b0;

        // Starvation: fetch held, data re-requests every cycle.
        tick();
        ireq_valid = 1'b1; ireq_addr = 64'h500;
        dreq_valid = 1'b1; dreq_addr = 64'h600; dreq_size = 3'd3; dreq_strobe = 8'h00;
        fetch_seen = 1'b0;
        for (int c = 0; c < 40 && !fetch_seen; c++) begin
            tick();
            if (mreq_valid) begin
                mresp_data_ok = 1'b1; mresp_data = 64'h5555_6666_7777_8888;
                owners.push_back(owner);
                if (!owner) fetch_seen = 1'b1;
            end else begin
                mresp_data_ok = 1'b0;
            end
        end
        check("t3_grant_count", 64'(owners.size()), 64'd5);
        for (int k = 0; k < 5 && k < owners.size(); k++)
            check("t3_grant_owner", {63'd0, owners[k]}, (k < 4) ? 64'd1 : 64'd0);
        tick();
        mresp_data_ok = 1'b0;
        tick();
        check("t3_cnt_cleared", {63'd0, owner}, 64'd1);
        mresp_data_ok = 1'b1;
        tick();
        mresp_data_ok = 1'b0; ireq_valid = 1'b0; dreq_valid = 1'b0;

        // Abandoned fetch.
        tick();
        ireq_valid = 1'b1; ireq_addr = 64'h40;
        tick();
        check("t4_owner", {63'd0, owner}, 64'd0);
        ireq_valid = 1'b0; ireq_addr = 64'h0;
        repeat (2) begin
            tick();
            check("t4_hold_valid", {63'd0, mreq_valid}, 64'd1);
            check("t4_hold_addr", mreq_addr, 64'h40);
        end
        tick();
        mresp_data_ok = 1'b1; mresp_data = 64'h9999_AAAA_BBBB_CCCC;
        #1;
        check("t4_no_iresp", {63'd0, iresp_data_ok}, 64'd0);
        check("t4_still_valid", {63'd0, mreq_valid}, 64'd1);
        tick();
        mresp_data_ok = 1'b0;
        check("t4_idle", {63'd0, mreq_valid}, 64'd0);

        // Asynchronous reset mid-write.
        dreq_valid = 1'b1; dreq_addr = 64'h3000; dreq_size = 3'd2;
        dreq_strobe = 8'h0F; dreq_data = 64'h1234_5678;
        tick();
        check("t5_busy", {63'd0, mreq_valid}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_drop", {63'd0, mreq_valid}, 64'd0);
        check("t5_no_dresp", {63'd0, dresp_data_ok}, 64'd0);
        tick();
        reset = 1'b0; dreq_valid = 1'b0; mresp_data_ok = 1'b1;
        #1;
        check("t5_late_resp", {63'd0, dresp_data_ok}, 64'd0);
        tick();
        mresp_data_ok = 1'b0; dreq_valid = 1'b1;
        tick();
        check("t5_regrant_valid", {63'd0, mreq_valid}, 64'd1);
        check("t5_regrant_owner", {63'd0, owner}, 64'd1);
        check("t5_regrant_addr", mreq_addr, 64'h3000);
        mresp_data_ok = 1'b1;
        #1;
        check("t5_dresp_ok", {63'd0, dresp_data_ok}, 64'd1);
        tick();
        mresp_data_ok = 1'b0; dreq_valid = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
